// File: rtl/cplx_buf_pkg.sv
// Shared definitions for the complex ping-pong buffer.
//   rd_state_t : read-side FSM states
//   bit_rev()  : reverses the low log2n bits of an index (upper bits zero)
package cplx_buf_pkg;

    localparam int unsigned MAX_LOG2N = 16;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_DRAIN = 1'b1
    } rd_state_t;

    function automatic logic [MAX_LOG2N-1:0] bit_rev(
        input logic [MAX_LOG2N-1:0] v,
        input int unsigned          log2n
    );
        logic [MAX_LOG2N-1:0] r;
        for (int unsigned i = 0; i < MAX_LOG2N; i++) begin
            r[MAX_LOG2N-1-i] = v[i];
        end
        return r >> (MAX_LOG2N - log2n);
    endfunction

endpackage

// File: rtl/cplx_pingpong_buf_if.sv
// Write/read stream bundle for cplx_pingpong_buf.
//   in_valid/in_ready, in_r/in_i            : write-side handshake and sample
//   out_valid/out_ready, out_r/out_i        : read-side handshake and sample
//   out_idx                                 : natural-order index of presented sample
//   out_last                                : final sample of a bank
// slave = buffer side, master = producer/consumer side.
interface cplx_pingpong_buf_if #(
    parameter int unsigned Q     = 16,
    parameter int unsigned LOG2N = 6
) ();
    logic             in_valid;
    logic             in_ready;
    logic [Q-1:0]     in_r;
    logic [Q-1:0]     in_i;
    logic             out_valid;
    logic             out_ready;
    logic [Q-1:0]     out_r;
    logic [Q-1:0]     out_i;
    logic [LOG2N-1:0] out_idx;
    logic             out_last;

    modport slave (
        input  in_valid, in_r, in_i, out_ready,
        output in_ready, out_valid, out_r, out_i, out_idx, out_last
    );

    modport master (
        output in_valid, in_r, in_i, out_ready,
        input  in_ready, out_valid, out_r, out_i, out_idx, out_last
    );
endinterface

// File: rtl/cplx_dp_ram.sv
// Simple dual-port RAM: synchronous write, registered read with enable.
// The array has no reset; the read register holds when re is low.
//   clk           : clock
//   we/waddr/wdata: write port
//   re/raddr/rdata: read port (rdata valid the cycle after re)
module cplx_dp_ram #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 7
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/cplx_pingpong_buf.sv
// Two-bank complex ping-pong buffer with natural or bit-reversed read order.
//   clk       : clock
//   rst_n     : asynchronous reset, active high
//   flush     : synchronous clear of all buffer state (memory untouched)
//   bitrev_en : read order for the next bank (latched when its drain starts)
//   bus       : write/read stream bundle (slave side)
//   ovf_err   : sticky, set on in_valid while in_ready is low
module cplx_pingpong_buf
    import cplx_buf_pkg::*;
#(
    parameter int unsigned Q     = 16,
    parameter int unsigned LOG2N = 6
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                flush,
    input  logic                bitrev_en,
    cplx_pingpong_buf_if.slave  bus,
    output logic                ovf_err
);
    logic [1:0]       full;
    logic             wbank, rbank, ibank;
    logic [LOG2N-1:0] wcnt, rcnt, rd_idx;
    rd_state_t        state;
    logic             br_mode;

    logic             s1_valid, s1_last;
    logic [LOG2N-1:0] s1_idx;
    logic [2*Q-1:0]   ram_q;

    logic wr_acc, issue, s1_adv, s2_adv, release_bank;

    assign bus.in_ready = ~full[wbank];
    assign wr_acc       = bus.in_valid & ~full[wbank] & ~flush;
    assign s2_adv       = ~bus.out_valid | bus.out_ready;
    assign s1_adv       = ~s1_valid | s2_adv;
    assign issue        = s1_adv & ((state == S_DRAIN) | full[ibank]);
    assign release_bank = bus.out_valid & bus.out_ready & bus.out_last;

    // rcnt is 0 on the first read of every bank, so the stale br_mode on that
    // cycle cannot affect the address.
    assign rd_idx = br_mode ? LOG2N'(bit_rev(MAX_LOG2N'(rcnt), LOG2N)) : rcnt;

    cplx_dp_ram #(.DW(2*Q), .AW(LOG2N+1)) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr ({wbank, wcnt}),
        .wdata ({bus.in_r, bus.in_i}),
        .re    (issue),
        .raddr ({ibank, rd_idx}),
        .rdata (ram_q)
    );

    // Write side, bank ownership and overflow flag.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            full    <= '0;
            wbank   <= 1'b0;
            rbank   <= 1'b0;
            wcnt    <= '0;
            ovf_err <= 1'b0;
        end else if (flush) begin
            full    <= '0;
            wbank   <= 1'b0;
            rbank   <= 1'b0;
            wcnt    <= '0;
            ovf_err <= 1'b0;
        end else begin
            if (wr_acc) begin
                if (&wcnt) begin
                    full[wbank] <= 1'b1;
                    wbank       <= ~wbank;
                    wcnt        <= '0;
                end else begin
                    wcnt <= wcnt + 1'b1;
                end
            end
            if (release_bank) begin
                full[rbank] <= 1'b0;
                rbank       <= ~rbank;
            end
            if (bus.in_valid & full[wbank]) ovf_err <= 1'b1;
        end
    end

    // Read FSM tracks the issue pointer (ibank), which runs up to two samples
    // ahead of rbank; this lets the next bank start while the previous tail is
    // still in the output pipeline, giving bubble-free bank changes.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state   <= S_IDLE;
            rcnt    <= '0;
            ibank   <= 1'b0;
            br_mode <= 1'b0;
        end else if (flush) begin
            state   <= S_IDLE;
            rcnt    <= '0;
            ibank   <= 1'b0;
            br_mode <= 1'b0;
        end else if (issue) begin
            if (&rcnt) begin
                rcnt  <= '0;
                ibank <= ~ibank;
                if (full[~ibank]) begin
                    state   <= S_DRAIN;
                    br_mode <= bitrev_en;
                end else begin
                    state <= S_IDLE;
                end
            end else begin
                rcnt <= rcnt + 1'b1;
                if (state == S_IDLE) begin
                    state   <= S_DRAIN;
                    br_mode <= bitrev_en;
                end
            end
        end
    end

    // Two-stage read pipeline: RAM output register (s1) then output register.
    // Both stages hold under backpressure, so the presented sample is stable.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            s1_valid      <= 1'b0;
            s1_idx        <= '0;
            s1_last       <= 1'b0;
            bus.out_valid <= 1'b0;
            bus.out_r     <= '0;
            bus.out_i     <= '0;
            bus.out_idx   <= '0;
            bus.out_last  <= 1'b0;
        end else if (flush) begin
            s1_valid      <= 1'b0;
            bus.out_valid <= 1'b0;
        end else begin
            if (s1_adv) begin
                s1_valid <= issue;
                s1_idx   <= rd_idx;
                s1_last  <= &rcnt;
            end
            if (s2_adv) begin
                bus.out_valid <= s1_valid;
                if (s1_valid) begin
                    bus.out_r    <= ram_q[2*Q-1:Q];
                    bus.out_i    <= ram_q[Q-1:0];
                    bus.out_idx  <= s1_idx;
                    bus.out_last <= s1_last;
                end
            end
        end
    end
endmodule

// File: tb/tb_cplx_pingpong_buf.sv
// Self-checking bench for cplx_pingpong_buf (Q=16, LOG2N=3).
module tb_cplx_pingpong_buf;
    localparam int unsigned Q = 16;
    localparam int unsigned L = 3;
    localparam int unsigned N = 8;

    logic clk, rst_n, flush, bitrev_en, ovf_err;

    cplx_pingpong_buf_if #(.Q(Q), .LOG2N(L)) bus ();

    cplx_pingpong_buf #(.Q(Q), .LOG2N(L)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .bitrev_en (bitrev_en),
        .bus       (bus),
        .ovf_err   (ovf_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic [15:0] r;
        logic [15:0] i;
        logic [2:0]  idx;
        logic        last;
    } samp_t;

    typedef struct {
        logic [15:0] r;
        logic [2:0]  idx;
        logic        last;
        int unsigned cyc;
    } got_t;

    typedef struct {
        logic        bitrev;
        logic        toggle;
        int unsigned order[8];
    } vec_t;

    int unsigned checks = 0;
    int unsigned failures = 0;
    int unsigned cyc = 0;

    samp_t       exp_q[$];
    got_t        got_q[$];
    logic [15:0] buf_r[8];
    logic [15:0] buf_i[8];
    int unsigned wr_cnt, full_cnt;
    logic        ovf_exp, mdl_br, last_in_hs;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic int unsigned rev(input int unsigned k);
        int unsigned r = 0;
        for (int unsigned b = 0; b < L; b++)
            if (((k >> b) & 1) != 0) r += (1 << (L - 1 - b));
        return r;
    endfunction

    task automatic mdl_clear();
        exp_q.delete();
        wr_cnt   = 0;
        full_cnt = 0;
        ovf_exp  = 1'b0;
    endtask

    // One clock: snapshot handshakes, advance, update model, compare.
    task automatic tick();
        logic        in_hs, out_hs, ovf_c, fl;
        logic [15:0] wr, wi;
        samp_t       s;
        got_t        g;
        in_hs  = bus.in_valid && bus.in_ready;
        out_hs = bus.out_valid && bus.out_ready;
        ovf_c  = bus.in_valid && !bus.in_ready;
        fl     = flush;
        wr     = bus.in_r;
        wi     = bus.in_i;
        if (out_hs) begin
            g.r = bus.out_r; g.idx = bus.out_idx; g.last = bus.out_last; g.cyc = cyc;
            got_q.push_back(g);
        end
        last_in_hs = in_hs;
        @(posedge clk);
        #1;
        cyc++;
        if (fl) begin
            mdl_clear();
        end else begin
            if (out_hs && exp_q.size() > 0) begin
                s = exp_q.pop_front();
                if (s.last) full_cnt--;
            end
            if (in_hs) begin
                buf_r[wr_cnt] = wr;
                buf_i[wr_cnt] = wi;
                wr_cnt++;
                if (wr_cnt == N) begin
                    for (int unsigned j = 0; j < N; j++) begin
                        int unsigned a;
                        a = mdl_br ? rev(j) : j;
                        s.r = buf_r[a]; s.i = buf_i[a]; s.idx = 3'(a); s.last = (j == N - 1);
                        exp_q.push_back(s);
                    end
                    full_cnt++;
                    wr_cnt = 0;
                end
            end
            if (ovf_c) ovf_exp = 1'b1;
        end
        check("in_ready", 64'(bus.in_ready), 64'(full_cnt < 2));
        check("ovf_err", 64'(ovf_err), 64'(ovf_exp));
        if (exp_q.size() == 0) check("out_valid_idle", 64'(bus.out_valid), 64'(0));
        if (bus.out_valid && exp_q.size() > 0) begin
            check("out_r", 64'(bus.out_r), 64'(exp_q[0].r));
            check("out_i", 64'(bus.out_i), 64'(exp_q[0].i));
            check("out_idx", 64'(bus.out_idx), 64'(exp_q[0].idx));
            check("out_last", 64'(bus.out_last), 64'(exp_q[0].last));
        end
    endtask

    task automatic write_sample(input logic [15:0] r, input logic [15:0] i);
        int unsigned n = 0;
        bus.in_valid = 1'b1;
        bus.in_r = r;
        bus.in_i = i;
        last_in_hs = 1'b0;
        while (!last_in_hs && n < 50) begin
            tick();
            n++;
        end
        check("write_accept", 64'(last_in_hs), 64'(1));
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input int unsigned bound);
        int unsigned n = 0;
        bus.out_ready = 1'b1;
        while ((exp_q.size() != 0 || bus.out_valid) && n < bound) begin
            tick();
            n++;
        end
        check("drain_idle", {63'(exp_q.size() != 0), bus.out_valid}, 64'(0));
    endtask

    task automatic do_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_out_valid"}, 64'(bus.out_valid), 64'(0));
        check({tag, "_out_last"}, 64'(bus.out_last), 64'(0));
        check({tag, "_out_r"}, 64'(bus.out_r), 64'(0));
        check({tag, "_out_i"}, 64'(bus.out_i), 64'(0));
        check({tag, "_out_idx"}, 64'(bus.out_idx), 64'(0));
        check({tag, "_ovf_err"}, 64'(ovf_err), 64'(0));
        check({tag, "_in_ready"}, 64'(bus.in_ready), 64'(1));
    endtask

    task automatic pulse_reset(input string tag);
        #2;
        rst_n = 1'b1;
        #1;
        check_reset_vals(tag);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        mdl_clear();
    endtask

    task automatic run_random(input logic br);
        int unsigned written = 0;
        int unsigned n = 0;
        mdl_br = br;
        bitrev_en = br;
        bus.in_r = 16'($urandom);
        bus.in_i = 16'($urandom);
        while ((written < 4 * N || exp_q.size() != 0 || bus.out_valid) && n < 3000) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.in_valid = (written < 4 * N);
            tick();
            n++;
            if (last_in_hs) begin
                written++;
                bus.in_r = 16'($urandom);
                bus.in_i = 16'($urandom);
            end
        end
        bus.in_valid = 1'b0;
        check("random_done", 64'(written), 64'(4 * N));
        check("random_drained", {63'(exp_q.size() != 0), bus.out_valid}, 64'(0));
    endtask

    localparam int unsigned NAT[8] = '{0, 1, 2, 3, 4, 5, 6, 7};
    localparam int unsigned BRV[8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    vec_t vec[4];

    initial begin
        int unsigned n;
        vec[0].bitrev = 1'b0; vec[0].toggle = 1'b0; vec[0].order = NAT;
        vec[1].bitrev = 1'b1; vec[1].toggle = 1'b0; vec[1].order = BRV;
        vec[2].bitrev = 1'b1; vec[2].toggle = 1'b1; vec[2].order = BRV;
        vec[3].bitrev = 1'b0; vec[3].toggle = 1'b1; vec[3].order = NAT;

        rst_n = 1'b0; flush = 1'b0; bitrev_en = 1'b0; mdl_br = 1'b0;
        bus.in_valid = 1'b0; bus.in_r = '0; bus.in_i = '0; bus.out_ready = 1'b0;
        last_in_hs = 1'b0;
        mdl_clear();
        #1 rst_n = 1'b1;
        #2 check_reset_vals("rst0");
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;

        // Table-driven single-bank order, latency and mid-bank bitrev toggle.
        for (int unsigned v = 0; v < 4; v++) begin
            bitrev_en = vec[v].bitrev;
            mdl_br = vec[v].bitrev;
            bus.out_ready = 1'b1;
            got_q.delete();
            for (int unsigned k = 0; k < N; k++) write_sample(16'(k), 16'(100 + k));
            n = 0;
            while (!bus.out_valid && n < 10) begin
                tick();
                n++;
            end
            check("first_valid_latency", 64'(n), 64'(2));
            if (vec[v].toggle) bitrev_en = ~bitrev_en;
            drain(100);
            check("tbl_count", 64'(got_q.size()), 64'(N));
            for (int unsigned j = 0; j < N && j < got_q.size(); j++) begin
                check("tbl_out_r", 64'(got_q[j].r), 64'(vec[v].order[j]));
                check("tbl_out_idx", 64'(got_q[j].idx), 64'(vec[v].order[j]));
                check("tbl_out_last", 64'(got_q[j].last), 64'(j == N - 1));
            end
        end

        // Both banks full under backpressure, overflow, then gap-free drain.
        bitrev_en = 1'b0; mdl_br = 1'b0;
        bus.out_ready = 1'b0;
        got_q.delete();
        for (int unsigned k = 0; k < 2 * N; k++) write_sample(16'(200 + k), 16'(3 * k));
        check("in_ready_full", 64'(bus.in_ready), 64'(0));
        bus.in_valid = 1'b1;
        tick();
        tick();
        bus.in_valid = 1'b0;
        check("ovf_set", 64'(ovf_err), 64'(1));
        tick();
        check("ovf_sticky", 64'(ovf_err), 64'(1));
        drain(100);
        check("stall_count", 64'(got_q.size()), 64'(2 * N));
        for (int unsigned j = 0; j < 2 * N && j < got_q.size(); j++) begin
            check("stall_order", 64'(got_q[j].r), 64'(200 + j));
            check("stall_no_gap", 64'(got_q[j].cyc), 64'(got_q[0].cyc + j));
        end
        do_flush();
        check("ovf_flush_clear", 64'(ovf_err), 64'(0));

        // Randomised streams with random output stalls.
        run_random(1'b1);
        do_flush();
        run_random(1'b0);
        do_flush();

        // Flush during drain, in the same cycle as a write.
        bitrev_en = 1'b0; mdl_br = 1'b0;
        bus.out_ready = 1'b1;
        got_q.delete();
        for (int unsigned k = 0; k < N; k++) write_sample(16'(400 + k), 16'(k));
        n = 0;
        while (got_q.size() < 5 && n < 30) begin
            tick();
            n++;
        end
        check("flush_reach_s5", 64'(got_q.size()), 64'(5));
        flush = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_r = 16'hDEAD;
        bus.in_i = 16'hBEEF;
        tick();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        check("flush_out_valid", 64'(bus.out_valid), 64'(0));
        check("flush_in_ready", 64'(bus.in_ready), 64'(1));
        check("flush_ovf", 64'(ovf_err), 64'(0));
        got_q.delete();
        for (int unsigned k = 0; k < N; k++) write_sample(16'(300 + k), 16'(k));
        drain(100);
        check("post_flush_count", 64'(got_q.size()), 64'(N));
        if (got_q.size() > 0) begin
            check("post_flush_first_r", 64'(got_q[0].r), 64'(300));
            check("post_flush_first_idx", 64'(got_q[0].idx), 64'(0));
        end

        // Asynchronous reset mid-fill and mid-drain.
        for (int unsigned k = 0; k < 3; k++) write_sample(16'(700 + k), 16'(k));
        pulse_reset("rst_fill");
        got_q.delete();
        for (int unsigned k = 0; k < N; k++) write_sample(16'(500 + k), 16'(50 + k));
        n = 0;
        while (got_q.size() < 3 && n < 30) begin
            tick();
            n++;
        end
        pulse_reset("rst_drain");
        for (int unsigned k = 0; k < 10; k++) tick();
        bitrev_en = 1'b1; mdl_br = 1'b1;
        got_q.delete();
        for (int unsigned k = 0; k < N; k++) write_sample(16'(600 + k), 16'(60 + k));
        drain(100);
        check("post_rst_count", 64'(got_q.size()), 64'(N));
        if (got_q.size() > 1) begin
            check("post_rst_r0", 64'(got_q[0].r), 64'(600));
            check("post_rst_r1", 64'(got_q[1].r), 64'(604));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cplx_pingpong_buf.md
CPLX_PINGPONG_BUF -- requirements
Module: cplx_pingpong_buf

Interface
REQ-001 Parameter: Q, 16, bit width of each real/imag sample component.
REQ-002 Parameter: LOG2N, 6, log2 of symbol length; N = 2**LOG2N samples per bank (N is derived, never set directly).
REQ-003 Port: clk  in  1  clock; all state updates on rising edge.
REQ-004 Port: rst_n  in  1  reset, asynchronous, active-high.
REQ-005 Port: flush  in  1  synchronous clear of all buffer state.
REQ-006 Port: bitrev_en  in  1  read-order select: 1 = bit-reversed, 0 = natural.
REQ-007 Port: in_valid / in_ready  in / out  1 / 1  write-side handshake.
REQ-008 Port: in_r, in_i  in  Q each  complex input sample.
REQ-009 Port: out_valid / out_ready  out / in  1 / 1  read-side handshake.
REQ-010 Port: out_r, out_i  out  Q each  complex output sample.
REQ-011 Port: out_idx  out  LOG2N  natural-order write index of the presented sample.
REQ-012 Port: out_last  out  1  high with the final sample of a bank.
REQ-013 Port: ovf_err  out  1  sticky overflow flag.

Function
REQ-014 Storage SHALL be two banks of N complex words; write side fills one bank while read side drains the other.
REQ-015 in_ready SHALL equal NOT full[wbank]; a write is accepted when in_valid AND in_ready are both high.
REQ-016 Accepted samples SHALL go to bank wbank, index wcnt; wcnt increments per accept.
REQ-017 On the accept with wcnt = N-1: set full[wbank], toggle wbank, reset wcnt to 0.
REQ-018 Read FSM states: IDLE (no full bank at rbank), DRAIN (issuing reads of rbank).
REQ-019 Transition IDLE->DRAIN: full[rbank] = 1. At this transition, latch bitrev_en and hold it for the whole bank.
REQ-020 Read address SHALL be rcnt (natural) or LOG2N-bit reversal of rcnt (bit-reversed).
REQ-021 out_idx SHALL carry that read address.
REQ-022 Read latency: first out_valid SHALL be 2 cycles after full[rbank] rises.
REQ-023 Throughput SHALL then be 1 sample/cycle while out_ready is held high.
REQ-024 While out_valid=1 and out_ready=0, out_r/out_i/out_idx/out_last SHALL hold stable; no sample is dropped or duplicated (internal skid stage).
REQ-025 On handshake of the out_last sample: clear full[rbank], toggle rbank, FSM to DRAIN if full[rbank^1] else IDLE.
REQ-026 Back-to-back banks SHALL stream with no bubble.
REQ-027 A bank freed by REQ-025 SHALL raise in_ready on the next cycle (registered; no combinational out_ready->in_ready path).
REQ-028 ovf_err SHALL set when in_valid=1 and in_ready=0; it clears only on flush or reset.
REQ-029 flush SHALL have priority over every other event in the same cycle: clear full[1:0], wbank, rbank, wcnt, rcnt, ovf_err and out_valid, and put the FSM in IDLE; the in-cycle write is discarded.
REQ-030 Memory contents SHALL NOT be cleared by reset or flush.

Reset
REQ-031 On rst_n high: out_valid, out_last, out_r, out_i, out_idx, ovf_err = 0; in_ready = 1; full = 2'b00; wbank = rbank = 0; counters = 0; FSM = IDLE.
REQ-032 Reset asserted mid-drain SHALL abandon the bank with no further out_valid until a new bank fills.

Structure
REQ-033 Shared package cplx_buf_pkg SHALL hold the read-FSM state enum and the bit-reverse function parameterised by LOG2N.
REQ-034 Storage SHALL be sub-module cplx_dp_ram: simple dual-port, 2N x 2Q, synchronous write and registered read, address = {bank, index}, no reset on the array.

Verification (LOG2N=3, Q=16)
REQ-035 Write in_r = 0..7 with out_ready=1, bitrev_en=0 -> out_r 0..7, out_last on 7, first out_valid 2 cycles after the 8th accept.
REQ-036 Same stimulus with bitrev_en=1 -> out_r order 0,4,2,6,1,5,3,7; out_idx matches; toggling bitrev_en mid-bank has no effect.
REQ-037 Write 16 samples with out_ready=0 -> in_ready low after the 16th accept; extra in_valid sets ovf_err; releasing out_ready yields all 16 in order, no gaps.
REQ-038 Random out_ready stalls over 4 continuous banks -> scoreboard exact match, outputs stable during stalls.
REQ-039 flush at sample 5 of a drain, same cycle as a write -> out_valid=0 and in_ready=1 next cycle, ovf_err=0, write discarded.
REQ-040 rst_n pulse mid-fill and mid-drain -> all REQ-031 values immediately (async); next full bank read correctly.
